// File: rtl/lsu_mem_stage.sv
// Memory-access stage: issues one AGU uop at a time to the data-memory port,
// aligns and extends load data, and writes back loads, stores and exceptions.
module lsu_mem_stage #(
  parameter int SQN_W = 6,
  parameter int TAG_W = 6,
  parameter int NM_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_branch_taken,
  input  logic [SQN_W-1:0] IN_branch_sqN,
  input  logic             IN_valid,
  input  logic [31:0]      IN_addr,
  input  logic [31:0]      IN_data,
  input  logic [3:0]       IN_wmask,
  input  logic             IN_isLoad,
  input  logic [1:0]       IN_shamt,
  input  logic [1:0]       IN_size,
  input  logic             IN_signExtend,
  input  logic             IN_exception,
  input  logic [31:0]      IN_pc,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [NM_W-1:0]  IN_nmDst,
  input  logic [SQN_W-1:0] IN_sqN,
  output logic             OUT_stall,
  output logic             OUT_mem_req,
  output logic             OUT_mem_we,
  output logic [29:0]      OUT_mem_addr,
  output logic [31:0]      OUT_mem_wdata,
  output logic [3:0]       OUT_mem_wmask,
  input  logic             IN_mem_ready,
  input  logic [31:0]      IN_mem_rdata,
  output logic             OUT_wb_valid,
  output logic [31:0]      OUT_wb_result,
  output logic             OUT_wb_exception,
  output logic [TAG_W-1:0] OUT_wb_tagDst,
  output logic [NM_W-1:0]  OUT_wb_nmDst,
  output logic [SQN_W-1:0] OUT_wb_sqN,
  output logic [31:0]      OUT_wb_pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state;
  logic             e_is_load;
  logic [1:0]       e_shamt;
  logic [1:0]       e_size;
  logic             e_sext;
  logic [31:0]      e_pc;
  logic [TAG_W-1:0] e_tag;
  logic [NM_W-1:0]  e_nm;
  logic [SQN_W-1:0] e_sqn;

  // Byte offset within the word is carried separately in IN_shamt.
  logic unused_addr_bits;
  assign unused_addr_bits = ^IN_addr[1:0];

  // True when uop a is strictly younger than branch b (wrap-around compare).
  function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  function automatic logic [31:0] align(input logic [31:0] rdata, input logic [1:0] shamt,
                                        input logic [1:0] size, input logic sext);
    logic [31:0] s;
    s = rdata >> {shamt, 3'b000};
    case (size)
      2'd0:    align = sext ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
      2'd1:    align = sext ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
      default: align = s;
    endcase
  endfunction

  logic in_flush;
  logic held_flush;
  assign in_flush   = IN_branch_taken && younger(IN_sqN, IN_branch_sqN);
  assign held_flush = IN_branch_taken && younger(e_sqn, IN_branch_sqN);

  assign OUT_stall = (state != S_IDLE);

  // Memory handshake: a request transfers on a rising edge where OUT_mem_req
  // and IN_mem_ready are both high; until then every OUT_mem_* field holds.
  // A flush of the held uop in that same cycle cancels the transfer, and read
  // data arrives on IN_mem_rdata in the cycle after a transferred read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      e_is_load        <= 1'b0;
      e_shamt          <= '0;
      e_size           <= '0;
      e_sext           <= 1'b0;
      e_pc             <= '0;
      e_tag            <= '0;
      e_nm             <= '0;
      e_sqn            <= '0;
      OUT_mem_req      <= 1'b0;
      OUT_mem_we       <= 1'b0;
      OUT_mem_addr     <= '0;
      OUT_mem_wdata    <= '0;
      OUT_mem_wmask    <= '0;
      OUT_wb_valid     <= 1'b0;
      OUT_wb_result    <= '0;
      OUT_wb_exception <= 1'b0;
      OUT_wb_tagDst    <= '0;
      OUT_wb_nmDst     <= '0;
      OUT_wb_sqN       <= '0;
      OUT_wb_pc        <= '0;
    end else begin
      OUT_wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IN_valid && !in_flush) begin
            e_is_load <= IN_isLoad;
            e_shamt   <= IN_shamt;
            e_size    <= IN_size;
            e_sext    <= IN_signExtend;
            e_pc      <= IN_pc;
            e_tag     <= IN_tagDst;
            e_nm      <= IN_nmDst;
            e_sqn     <= IN_sqN;
            if (IN_exception) begin
              OUT_wb_valid     <= 1'b1;
              OUT_wb_result    <= '0;
              OUT_wb_exception <= 1'b1;
              OUT_wb_tagDst    <= IN_tagDst;
              OUT_wb_nmDst     <= IN_nmDst;
              OUT_wb_sqN       <= IN_sqN;
              OUT_wb_pc        <= IN_pc;
            end else begin
              state         <= S_ISSUE;
              OUT_mem_req   <= 1'b1;
              OUT_mem_we    <= !IN_isLoad;
              OUT_mem_addr  <= IN_addr[31:2];
              OUT_mem_wdata <= IN_data;
              OUT_mem_wmask <= IN_wmask;
            end
          end
        end
        S_ISSUE: begin
          if (held_flush) begin
            OUT_mem_req <= 1'b0;
            state       <= S_IDLE;
          end else if (IN_mem_ready) begin
            OUT_mem_req <= 1'b0;
            if (e_is_load) begin
              state <= S_WAIT;
            end else begin
              state            <= S_IDLE;
              OUT_wb_valid     <= 1'b1;
              OUT_wb_result    <= '0;
              OUT_wb_exception <= 1'b0;
              OUT_wb_tagDst    <= e_tag;
              OUT_wb_nmDst     <= e_nm;
              OUT_wb_sqN       <= e_sqn;
              OUT_wb_pc        <= e_pc;
            end
          end
        end
        S_WAIT: begin
          state <= S_IDLE;
          if (!held_flush) begin
            OUT_wb_valid     <= 1'b1;
            OUT_wb_result    <= align(IN_mem_rdata, e_shamt, e_size, e_sext);
            OUT_wb_exception <= 1'b0;
            OUT_wb_tagDst    <= e_tag;
            OUT_wb_nmDst     <= e_nm;
            OUT_wb_sqN       <= e_sqn;
            OUT_wb_pc        <= e_pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: per-scenario tasks with inline checks and
// a simple read-data responder standing in for the data memory.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IN_branch_taken;
  logic [5:0]  IN_branch_sqN;
  logic        IN_valid;
  logic [31:0] IN_addr;
  logic [31:0] IN_data;
  logic [3:0]  IN_wmask;
  logic        IN_isLoad;
  logic [1:0]  IN_shamt;
  logic [1:0]  IN_size;
  logic        IN_signExtend;
  logic        IN_exception;
  logic [31:0] IN_pc;
  logic [5:0]  IN_tagDst;
  logic [4:0]  IN_nmDst;
  logic [5:0]  IN_sqN;
  logic        OUT_stall;
  logic        OUT_mem_req;
  logic        OUT_mem_we;
  logic [29:0] OUT_mem_addr;
  logic [31:0] OUT_mem_wdata;
  logic [3:0]  OUT_mem_wmask;
  logic        IN_mem_ready;
  logic [31:0] IN_mem_rdata;
  logic        OUT_wb_valid;
  logic [31:0] OUT_wb_result;
  logic        OUT_wb_exception;
  logic [5:0]  OUT_wb_tagDst;
  logic [4:0]  OUT_wb_nmDst;
  logic [5:0]  OUT_wb_sqN;
  logic [31:0] OUT_wb_pc;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] mem_word = '0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.SQN_W(6), .TAG_W(6), .NM_W(5)) dut (
    .clk(clk), .rst(rst),
    .IN_branch_taken(IN_branch_taken), .IN_branch_sqN(IN_branch_sqN),
    .IN_valid(IN_valid), .IN_addr(IN_addr), .IN_data(IN_data), .IN_wmask(IN_wmask),
    .IN_isLoad(IN_isLoad), .IN_shamt(IN_shamt), .IN_size(IN_size),
    .IN_signExtend(IN_signExtend), .IN_exception(IN_exception), .IN_pc(IN_pc),
    .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst), .IN_sqN(IN_sqN),
    .OUT_stall(OUT_stall), .OUT_mem_req(OUT_mem_req), .OUT_mem_we(OUT_mem_we),
    .OUT_mem_addr(OUT_mem_addr), .OUT_mem_wdata(OUT_mem_wdata), .OUT_mem_wmask(OUT_mem_wmask),
    .IN_mem_ready(IN_mem_ready), .IN_mem_rdata(IN_mem_rdata),
    .OUT_wb_valid(OUT_wb_valid), .OUT_wb_result(OUT_wb_result),
    .OUT_wb_exception(OUT_wb_exception), .OUT_wb_tagDst(OUT_wb_tagDst),
    .OUT_wb_nmDst(OUT_wb_nmDst), .OUT_wb_sqN(OUT_wb_sqN), .OUT_wb_pc(OUT_wb_pc)
  );

  // Memory model: returns mem_word the cycle after an accepted read, noise otherwise.
  always @(posedge clk) begin
    if (OUT_mem_req && IN_mem_ready && !OUT_mem_we) begin
      #1 IN_mem_rdata = mem_word;
    end else begin
      #1 IN_mem_rdata = $urandom;
    end
  end

  task automatic clear_inputs();
    IN_branch_taken = 1'b0; IN_branch_sqN = '0; IN_valid = 1'b0; IN_addr = '0;
    IN_data = '0; IN_wmask = '0; IN_isLoad = 1'b0; IN_shamt = '0; IN_size = '0;
    IN_signExtend = 1'b0; IN_exception = 1'b0; IN_pc = '0; IN_tagDst = '0;
    IN_nmDst = '0; IN_sqN = '0; IN_mem_ready = 1'b0;
  endtask

  task automatic set_uop(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wmask,
                         input logic is_load, input logic [1:0] shamt, input logic [1:0] size,
                         input logic sext, input logic exc, input logic [5:0] sqn);
    IN_valid = 1'b1; IN_addr = addr; IN_data = data; IN_wmask = wmask; IN_isLoad = is_load;
    IN_shamt = shamt; IN_size = size; IN_signExtend = sext; IN_exception = exc;
    IN_pc = addr + 32'h1000; IN_tagDst = sqn + 6'd1; IN_nmDst = sqn[4:0]; IN_sqN = sqn;
  endtask

  // Drives one uop from IDLE and waits (bounded) for its writeback.
  task automatic do_uop(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wmask,
                        input logic is_load, input logic [1:0] shamt, input logic [1:0] size,
                        input logic sext, input logic exc, input logic [5:0] sqn,
                        input logic [31:0] rdata, input int ready_delay,
                        output logic seen, output logic [31:0] res, output logic wexc,
                        output int lat, output int req_cycles);
    mem_word = rdata;
    set_uop(addr, data, wmask, is_load, shamt, size, sext, exc, sqn);
    @(posedge clk); #1 IN_valid = 1'b0;
    seen = 1'b0; res = '0; wexc = 1'b0; lat = 0; req_cycles = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      IN_mem_ready = (c > ready_delay);
      @(negedge clk);
      if (OUT_mem_req) req_cycles++;
      if (OUT_wb_valid) begin
        seen = 1'b1; res = OUT_wb_result; wexc = OUT_wb_exception; lat = c;
      end
      @(posedge clk); #1;
    end
    IN_mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({OUT_stall, OUT_mem_req, OUT_wb_valid} !== 3'b000)
      $display("FAIL reset_ctrl got=%b exp=000", {OUT_stall, OUT_mem_req, OUT_wb_valid});
    else pass_cnt++;
    total_cnt++;
    if ({OUT_mem_we, OUT_mem_addr, OUT_mem_wdata, OUT_mem_wmask} !== 67'd0)
      $display("FAIL reset_mem got addr=%h wdata=%h", OUT_mem_addr, OUT_mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({OUT_wb_result, OUT_wb_exception, OUT_wb_tagDst, OUT_wb_nmDst, OUT_wb_sqN, OUT_wb_pc} !== 82'd0)
      $display("FAIL reset_wb got result=%h pc=%h exp=0", OUT_wb_result, OUT_wb_pc);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_load_word();
    mem_word = 32'h8765_4321;
    set_uop(32'h100, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 6'd10);
    @(posedge clk); #1 IN_valid = 1'b0; IN_mem_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({OUT_stall, OUT_mem_req, OUT_mem_we, OUT_mem_addr} !== {1'b1, 1'b1, 1'b0, 30'h40})
      $display("FAIL lw_req got stall=%b req=%b we=%b addr=%h exp 1 1 0 40",
               OUT_stall, OUT_mem_req, OUT_mem_we, OUT_mem_addr);
    else pass_cnt++;
    @(posedge clk); #1 IN_mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_stall, OUT_mem_req, OUT_wb_valid} !== 3'b100)
      $display("FAIL lw_wait got stall/req/wb=%b exp=100", {OUT_stall, OUT_mem_req, OUT_wb_valid});
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if ({OUT_wb_valid, OUT_stall, OUT_wb_exception, OUT_wb_result} !== {3'b100, 32'h8765_4321})
      $display("FAIL lw_wb got valid=%b stall=%b exc=%b result=%h exp 1 0 0 87654321",
               OUT_wb_valid, OUT_stall, OUT_wb_exception, OUT_wb_result);
    else pass_cnt++;
    total_cnt++;
    if ({OUT_wb_tagDst, OUT_wb_nmDst, OUT_wb_sqN, OUT_wb_pc} !== {6'd11, 5'd10, 6'd10, 32'h1100})
      $display("FAIL lw_wb_fields got tag=%0d nm=%0d sqn=%0d pc=%h exp 11 10 10 1100",
               OUT_wb_tagDst, OUT_wb_nmDst, OUT_wb_sqN, OUT_wb_pc);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (OUT_wb_valid !== 1'b0) $display("FAIL lw_wb_pulse got=%b exp=0", OUT_wb_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_load_align();
    logic [31:0] v_addr [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104, 32'h101};
    logic [1:0]  v_sh   [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [1:0]  v_sz   [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
    logic        v_sx   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] v_rd   [6] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_0000,
                                32'h1234_F00D, 32'hCAFE_BABE, 32'h1234_5678};
    logic [31:0] v_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                32'h0000_F00D, 32'hCAFE_BABE, 32'h0000_0056};
    logic seen, wexc;
    logic [31:0] res;
    int lat, reqs;
    for (int i = 0; i < 6; i++) begin
      do_uop(v_addr[i], 32'h0, 4'h0, 1'b1, v_sh[i], v_sz[i], v_sx[i], 1'b0, 6'(20 + i),
             v_rd[i], 0, seen, res, wexc, lat, reqs);
      total_cnt++;
      if (!seen || res !== v_exp[i] || lat != 3)
        $display("FAIL load_align[%0d] got seen=%b result=%h lat=%0d exp result=%h lat=3",
                 i, seen, res, lat, v_exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_stall();
    set_uop(32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 6'd30);
    @(posedge clk); #1 IN_valid = 1'b0; IN_mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) IN_mem_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({OUT_mem_req, OUT_mem_we, OUT_mem_addr, OUT_mem_wdata, OUT_mem_wmask, OUT_wb_valid} !==
          {1'b1, 1'b1, 30'h80, 32'hDEAD_BEEF, 4'hF, 1'b0})
        $display("FAIL sw_hold[%0d] got req=%b we=%b addr=%h wdata=%h wmask=%h wb=%b", c,
                 OUT_mem_req, OUT_mem_we, OUT_mem_addr, OUT_mem_wdata, OUT_mem_wmask, OUT_wb_valid);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    IN_mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_mem_req, OUT_wb_valid, OUT_wb_exception, OUT_wb_result, OUT_wb_sqN} !==
        {3'b010, 32'h0, 6'd30})
      $display("FAIL sw_wb got req=%b wb=%b exc=%b result=%h sqn=%0d exp 0 1 0 0 30",
               OUT_mem_req, OUT_wb_valid, OUT_wb_exception, OUT_wb_result, OUT_wb_sqN);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if ({OUT_wb_valid, OUT_stall} !== 2'b00)
      $display("FAIL sw_after got wb/stall=%b exp=00", {OUT_wb_valid, OUT_stall});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic wb_seen;
    logic seen;
    logic [31:0] res;
    // Branch sqN=3 is older than the held load (sqN=5): squash.
    mem_word = 32'h1111_2222;
    set_uop(32'h300, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 6'd5);
    @(posedge clk); #1 IN_valid = 1'b0; IN_mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (OUT_mem_req !== 1'b1) $display("FAIL flush_pre_req got=%b exp=1", OUT_mem_req);
    else pass_cnt++;
    @(posedge clk); #1 IN_branch_taken = 1'b1; IN_branch_sqN = 6'd3;
    @(posedge clk); #1 IN_branch_taken = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_mem_req, OUT_stall} !== 2'b00)
      $display("FAIL flush_drop got req/stall=%b exp=00", {OUT_mem_req, OUT_stall});
    else pass_cnt++;
    wb_seen = OUT_wb_valid;
    repeat (4) begin
      @(negedge clk);
      wb_seen |= OUT_wb_valid;
    end
    total_cnt++;
    if (wb_seen !== 1'b0) $display("FAIL flush_no_wb got wb=%b exp=0", wb_seen);
    else pass_cnt++;
    @(posedge clk); #1;
    // Branch sqN=7 is younger than the held load: it must complete.
    mem_word = 32'h0BAD_F00D;
    set_uop(32'h304, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 6'd5);
    @(posedge clk); #1 IN_valid = 1'b0; IN_branch_taken = 1'b1; IN_branch_sqN = 6'd7;
    @(posedge clk); #1 IN_branch_taken = 1'b0; IN_mem_ready = 1'b1;
    seen = 1'b0; res = '0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (OUT_wb_valid) begin seen = 1'b1; res = OUT_wb_result; end
      @(posedge clk); #1 IN_mem_ready = 1'b0;
    end
    total_cnt++;
    if (!seen || res !== 32'h0BAD_F00D)
      $display("FAIL noflush_load got seen=%b result=%h exp=0badf00d", seen, res);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic wb_seen;
    // Held sqN=1 vs branch 62 wraps to +3: squashed, even with ready high.
    mem_word = 32'h3333_4444;
    set_uop(32'h400, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 6'd1);
    @(posedge clk); #1 IN_valid = 1'b0; IN_branch_taken = 1'b1; IN_branch_sqN = 6'd62;
    IN_mem_ready = 1'b1;
    @(posedge clk); #1 IN_branch_taken = 1'b0; IN_mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_mem_req, OUT_stall} !== 2'b00)
      $display("FAIL wrap_drop got req/stall=%b exp=00", {OUT_mem_req, OUT_stall});
    else pass_cnt++;
    wb_seen = OUT_wb_valid;
    repeat (4) begin
      @(negedge clk);
      wb_seen |= OUT_wb_valid;
    end
    total_cnt++;
    if (wb_seen !== 1'b0) $display("FAIL wrap_no_wb got wb=%b exp=0", wb_seen);
    else pass_cnt++;
    @(posedge clk); #1;
    // Incoming uop squashed in the same cycle it is offered.
    set_uop(32'h408, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 6'd1);
    IN_branch_taken = 1'b1; IN_branch_sqN = 6'd62;
    @(posedge clk); #1 IN_valid = 1'b0; IN_branch_taken = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_stall, OUT_mem_req, OUT_wb_valid} !== 3'b000)
      $display("FAIL wrap_incoming got stall/req/wb=%b exp=000", {OUT_stall, OUT_mem_req, OUT_wb_valid});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_exception();
    logic seen, wexc;
    logic [31:0] res;
    int lat, reqs;
    do_uop(32'h500, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 6'd40, 32'h5555_5555, 0,
           seen, res, wexc, lat, reqs);
    total_cnt++;
    if (!seen || wexc !== 1'b1 || res !== 32'h0 || lat != 1 || reqs != 0)
      $display("FAIL exc_wb got seen=%b exc=%b result=%h lat=%0d reqs=%0d exp 1 1 0 1 0",
               seen, wexc, res, lat, reqs);
    else pass_cnt++;
    // sqN=62 vs branch 1 wraps to -3: older than the branch, so accepted.
    set_uop(32'h504, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 6'd62);
    IN_branch_taken = 1'b1; IN_branch_sqN = 6'd1;
    @(posedge clk); #1 IN_valid = 1'b0; IN_branch_taken = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_wb_valid, OUT_wb_exception, OUT_wb_sqN, OUT_mem_req} !== {2'b11, 6'd62, 1'b0})
      $display("FAIL exc_wrap_accept got wb=%b exc=%b sqn=%0d req=%b exp 1 1 62 0",
               OUT_wb_valid, OUT_wb_exception, OUT_wb_sqN, OUT_mem_req);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait();
    logic wb_seen;
    mem_word = 32'h55AA_55AA;
    set_uop(32'h600, 32'h0, 4'h0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 6'd9);
    @(posedge clk); #1 IN_valid = 1'b0; IN_mem_ready = 1'b1;
    @(posedge clk); #1 IN_mem_ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({OUT_stall, OUT_mem_req} !== 2'b10)
      $display("FAIL rstwait_in_wait got stall/req=%b exp=10", {OUT_stall, OUT_mem_req});
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({OUT_stall, OUT_mem_req, OUT_wb_valid, OUT_mem_addr, OUT_wb_result, OUT_wb_sqN} !== 71'd0)
      $display("FAIL rstwait_clear got stall=%b req=%b wb=%b addr=%h result=%h",
               OUT_stall, OUT_mem_req, OUT_wb_valid, OUT_mem_addr, OUT_wb_result);
    else pass_cnt++;
    wb_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      wb_seen |= OUT_wb_valid;
    end
    total_cnt++;
    if (wb_seen !== 1'b0) $display("FAIL rstwait_no_wb got wb=%b exp=0", wb_seen);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic seen, wexc;
    logic [31:0] res;
    int lat, reqs;
    do_uop(32'h700, 32'h0123_4567, 4'h3, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 6'd50, 32'h0, 0,
           seen, res, wexc, lat, reqs);
    total_cnt++;
    if (!seen || res !== 32'h0 || lat != 2 || reqs != 1)
      $display("FAIL b2b_store got seen=%b result=%h lat=%0d reqs=%0d exp 1 0 2 1", seen, res, lat, reqs);
    else pass_cnt++;
    do_uop(32'h706, 32'h0, 4'h0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 6'd51, 32'h7FFF_0000, 2,
           seen, res, wexc, lat, reqs);
    total_cnt++;
    if (!seen || res !== 32'h0000_7FFF || lat != 5 || reqs != 3)
      $display("FAIL b2b_load got seen=%b result=%h lat=%0d reqs=%0d exp 1 00007fff 5 3",
               seen, res, lat, reqs);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_load_word();
    test_load_align();
    test_store_stall();
    test_flush();
    test_wrap();
    test_exception();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
